theta_step: RTL and testbench

- Implements the Keccak-f[1600] theta step (FIPS 202 §3.2.1) on a full 5x5x64 state array.
- Sits in the keccak-engine round datapath ahead of rho/pi/chi/iota.
- Combinational theta core feeds one output register stage with a valid flag.
- Latency is one clock.

---
 rtl/theta_step.sv | 54 +++++
 tb/tb_theta_step.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/theta_step.sv
// Keccak-f[1600] theta step: combinational column-parity mixing followed by
// a single output register stage carrying a valid flag.
module theta_step #(
  localparam int ROW_SIZE  = 5,
  localparam int COL_SIZE  = 5,
  localparam int LANE_SIZE = 64
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_in,
  output logic                                         out_valid,
  output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_out
);

  logic [ROW_SIZE-1:0][LANE_SIZE-1:0]                col_parity;
  logic [ROW_SIZE-1:0][LANE_SIZE-1:0]                theta_effect;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] theta_out;

  always_comb begin
    col_parity   = '0;
    theta_effect = '0;
    theta_out    = '0;
    for (int x = 0; x < ROW_SIZE; x++) begin
      for (int y = 0; y < COL_SIZE; y++) begin
        col_parity[x] = col_parity[x] ^ state_array_in[x][y];
      end
    end
    // Neighbour at x-1 taken as-is; neighbour at x+1 rotated left by one bit.
    for (int x = 0; x < ROW_SIZE; x++) begin
      theta_effect[x] = col_parity[(x + ROW_SIZE - 1) % ROW_SIZE]
                      ^ {col_parity[(x + 1) % ROW_SIZE][LANE_SIZE-2:0],
                         col_parity[(x + 1) % ROW_SIZE][LANE_SIZE-1]};
    end
    for (int x = 0; x < ROW_SIZE; x++) begin
      for (int y = 0; y < COL_SIZE; y++) begin
        theta_out[x][y] = state_array_in[x][y] ^ theta_effect[x];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      state_array_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_array_out <= theta_out;
      end
    end
  end

endmodule

// File: tb/tb_theta_step.sv
// Directed-vector bench for theta_step: hand-computed table, reset, streaming,
// hold and linearity sequences against an independent bit-level model.
module tb_theta_step;

  typedef logic [4:0][4:0][63:0] state_t;

  typedef struct {
    string  name;
    state_t a;
    state_t exp;
  } vec_t;

  logic   clk;
  logic   rst_n;
  logic   in_valid;
  state_t state_array_in;
  logic   out_valid;
  state_t state_array_out;

  int checks;
  int errors;

  theta_step dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .state_array_in  (state_array_in),
    .out_valid       (out_valid),
    .state_array_out (state_array_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-at-a-time reference: A'[x][y][z] = A[x][y][z] ^ par(x-1, z) ^ par(x+1, z-1).
  function automatic state_t theta_model(input state_t a);
    state_t r;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        for (int z = 0; z < 64; z++) begin
          logic b;
          b = a[x][y][z];
          for (int yy = 0; yy < 5; yy++) begin
            b = b ^ a[(x + 4) % 5][yy][z] ^ a[(x + 1) % 5][yy][(z + 63) % 64];
          end
          r[x][y][z] = b;
        end
      end
    end
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        s[x][y] = {$urandom(), $urandom()};
      end
    end
    return s;
  endfunction

  task automatic check_state(input string name, input state_t act, input state_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int x = 0; x < 5; x++) begin
        for (int y = 0; y < 5; y++) begin
          if (act[x][y] !== exp[x][y]) begin
            $display("FAIL %s: lane[%0d][%0d] actual %h required %h", name, x, y,
                     act[x][y], exp[x][y]);
            return;
          end
        end
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  vec_t   vecs[4];
  state_t s, e, prev_exp, out_a, out_b, out_ab, ra, rb;

  initial begin
    // Hand-computed vectors
    vecs[0].name = "single_bit";
    vecs[0].a = '0;
    vecs[0].a[0][0] = 64'h1;
    vecs[0].exp = '0;
    vecs[0].exp[0][0] = 64'h1;
    for (int y = 0; y < 5; y++) begin
      vecs[0].exp[1][y] = 64'h1;
      vecs[0].exp[4][y] = 64'h2;
    end

    vecs[1].name = "wrap_bit";
    vecs[1].a = '0;
    vecs[1].a[2][3] = 64'h8000_0000_0000_0000;
    vecs[1].exp = '0;
    vecs[1].exp[2][3] = 64'h8000_0000_0000_0000;
    for (int y = 0; y < 5; y++) begin
      vecs[1].exp[3][y] = 64'h8000_0000_0000_0000;
      vecs[1].exp[1][y] = 64'h1;
    end

    vecs[2].name = "all_ones";
    vecs[2].a   = '1;
    vecs[2].exp = '1;

    vecs[3].name = "all_zero";
    vecs[3].a   = '0;
    vecs[3].exp = '0;

    checks = 0;
    errors = 0;

    // Asynchronous reset with active inputs, no clock edge in between
    rst_n = 1'b1;
    in_valid = 1'b1;
    state_array_in = rand_state();
    #2 rst_n = 1'b0;
    #1;
    check_bit("reset_valid_async", out_valid, 1'b0);
    check_state("reset_data_async", state_array_out, '0);
    repeat (2) @(negedge clk);
    check_bit("reset_hold_valid", out_valid, 1'b0);
    check_state("reset_hold_data", state_array_out, '0);

    // Release: first edge captures
    s = rand_state();
    state_array_in = s;
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("post_reset_valid", out_valid, 1'b1);
    check_state("post_reset_data", state_array_out, theta_model(s));

    // Mid-stream reset discards the registered result
    state_array_in = rand_state();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_bit("midstream_reset_valid", out_valid, 1'b0);
    check_state("midstream_reset_data", state_array_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      state_array_in = vecs[i].a;
      @(negedge clk);
      check_bit({vecs[i].name, "_valid"}, out_valid, 1'b1);
      check_state(vecs[i].name, state_array_out, vecs[i].exp);
    end

    // Streaming: one result per cycle
    s = rand_state();
    state_array_in = s;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      e = theta_model(s);
      check_bit("stream_valid", out_valid, 1'b1);
      check_state("stream_data", state_array_out, e);
      prev_exp = e;
      if (i < 99) begin
        s = rand_state();
        state_array_in = s;
      end
    end

    // Drop in_valid: output holds
    in_valid = 1'b0;
    state_array_in = rand_state();
    @(negedge clk);
    check_bit("hold_valid", out_valid, 1'b0);
    check_state("hold_data", state_array_out, prev_exp);

    // Unknown input while idle must not disturb the output
    state_array_in = 'x;
    repeat (2) @(negedge clk);
    check_bit("x_idle_valid", out_valid, 1'b0);
    check_state("x_idle_data", state_array_out, prev_exp);

    // Linearity: out(a) ^ out(b) == out(a ^ b)
    ra = rand_state();
    rb = rand_state();
    in_valid = 1'b1;
    state_array_in = ra;
    @(negedge clk);
    out_a = state_array_out;
    check_state("lin_a_model", out_a, theta_model(ra));
    state_array_in = rb;
    @(negedge clk);
    out_b = state_array_out;
    check_state("lin_b_model", out_b, theta_model(rb));
    state_array_in = ra ^ rb;
    @(negedge clk);
    out_ab = state_array_out;
    check_state("linearity", out_ab, out_a ^ out_b);
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("final_idle_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
